// File: rtl/fifo_burst_reader_if.sv
// Stream-side bundle for fifo_burst_reader: FIFO read port plus the outgoing
// valid/ready beat stream. master = the reader, slave = FIFO/consumer side.
interface fifo_burst_reader_if #(
  parameter int BW     = 8,
  parameter int LGFLEN = 4
);
  logic              o_fifo_rd;
  logic [BW-1:0]     i_fifo_data;
  logic              i_fifo_empty;
  logic [LGFLEN:0]   i_fifo_fill;
  logic              o_valid;
  logic              i_ready;
  logic [BW-1:0]     o_data;
  logic              o_last;

  modport master (
    output o_fifo_rd, o_valid, o_data, o_last,
    input  i_fifo_data, i_fifo_empty, i_fifo_fill, i_ready
  );

  modport slave (
    input  o_fifo_rd, o_valid, o_data, o_last,
    output i_fifo_data, i_fifo_empty, i_fifo_fill, i_ready
  );
endinterface

// File: rtl/fifo_burst_reader.sv
// Drains an async-read FIFO in fixed bursts (or a short flush after idle
// timeout) onto a registered valid/ready stream with a last-beat marker.
module fifo_burst_reader #(
  parameter int BW        = 8,
  parameter int LGFLEN    = 4,
  parameter int LGBURST   = 2,
  parameter int LGTIMEOUT = 8
) (
  input  logic i_clk,
  input  logic i_reset,
  fifo_burst_reader_if.master bus
);
  localparam int                  BURST      = 1 << LGBURST;
  localparam logic [LGFLEN:0]     BURST_FILL = (LGFLEN+1)'(BURST);
  localparam logic [LGBURST:0]    BURST_LEN  = (LGBURST+1)'(BURST);
  localparam logic [LGTIMEOUT-1:0] TMAX      = '1;

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t                 r_state, w_state_nxt;
  logic [LGBURST:0]       r_remaining, w_remaining_nxt;
  logic [LGTIMEOUT-1:0]   r_tcount, w_tcount_nxt;
  logic                   r_valid, r_last;
  logic [BW-1:0]          r_data;
  logic                   w_rd, w_accept_last;

  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_tcount_nxt    = r_tcount;
    w_rd            = 1'b0;
    w_accept_last   = r_valid && bus.i_ready && r_last;
    case (r_state)
      S_IDLE: begin
        if (bus.i_fifo_fill >= BURST_FILL) begin
          w_state_nxt     = S_BURST;
          w_remaining_nxt = BURST_LEN;
          w_tcount_nxt    = '0;
        end else if (!bus.i_fifo_empty && r_tcount == TMAX) begin
          // fill < BURST here, so the low bits hold the whole count
          w_state_nxt     = S_BURST;
          w_remaining_nxt = bus.i_fifo_fill[LGBURST:0];
          w_tcount_nxt    = '0;
        end else if (!bus.i_fifo_empty) begin
          w_tcount_nxt    = r_tcount + 1'b1;
        end else begin
          w_tcount_nxt    = '0;
        end
      end
      S_BURST: begin
        w_rd = (r_remaining != '0) && !bus.i_fifo_empty && (!r_valid || bus.i_ready);
        if (w_rd)
          w_remaining_nxt = r_remaining - 1'b1;
        if (w_accept_last)
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_tcount    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      r_tcount    <= w_tcount_nxt;
    end
  end

  // Output register loads on every FIFO read; an accept with no refill empties it
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_data  <= '0;
    end else if (w_rd) begin
      r_valid <= 1'b1;
      r_last  <= (r_remaining == (LGBURST+1)'(1));
      r_data  <= bus.i_fifo_data;
    end else if (bus.i_ready) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  assign bus.o_fifo_rd = w_rd;
  assign bus.o_valid   = r_valid;
  assign bus.o_last    = r_last;
  assign bus.o_data    = r_data;
endmodule
